// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the unified instruction/data memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned BE_W     = DATA_W / 8;
  localparam int unsigned STARVE_W = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Counts consecutive data grants taken while a fetch waits; flags when fetch must win.
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic if_req_i,
  input  logic if_gnt_i,
  input  logic dm_gnt_i,
  output logic starved_o
);

  localparam logic [STARVE_W-1:0] CntMax = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (if_gnt_i || !if_req_i) begin
      starve_cnt_d = '0;
    end else if (dm_gnt_i && (starve_cnt_q != CntMax)) begin
      starve_cnt_d = starve_cnt_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign starved_o = (starve_cnt_q == CntMax);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: data-priority grant with fetch starvation guard and
// one-cycle response routing back to the owning port.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic                  if_req_i,
  input  logic [ADDR_W-1:0]     if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_W-1:0]     if_rdata_o,
  input  logic                  flush_i,

  input  logic                  dm_req_i,
  input  logic                  dm_we_i,
  input  logic [DATA_W/8-1:0]   dm_be_i,
  input  logic [ADDR_W-1:0]     dm_addr_i,
  input  logic [DATA_W-1:0]     dm_wdata_i,
  output logic                  dm_gnt_o,
  output logic                  dm_rvalid_o,
  output logic [DATA_W-1:0]     dm_rdata_o,

  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [DATA_W/8-1:0]   mem_be_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  input  logic [DATA_W-1:0]     mem_rdata_i
);

  logic   if_gnt, dm_gnt, starved;
  owner_e resp_owner_q, resp_owner_d;
  logic   we_q, we_d;

  mem_arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve_ctr (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .if_req_i (if_req_i),
    .if_gnt_i (if_gnt),
    .dm_gnt_i (dm_gnt),
    .starved_o(starved)
  );

  // Flush vetoes fetch outright, so data wins even when fetch is starved.
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (!rst_i) begin
      if_gnt = if_req_i && !flush_i && (!dm_req_i || starved);
      dm_gnt = dm_req_i && !if_gnt;
    end
  end

  assign if_gnt_o = if_gnt;
  assign dm_gnt_o = dm_gnt;

  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (if_gnt) begin
      mem_en_o   = 1'b1;
      mem_be_o   = '1;
      mem_addr_o = if_addr_i;
    end else if (dm_gnt) begin
      mem_en_o    = 1'b1;
      mem_we_o    = dm_we_i;
      mem_be_o    = dm_be_i;
      mem_addr_o  = dm_addr_i;
      mem_wdata_o = dm_wdata_i;
    end
  end

  // Response owner state: register, next-state, outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_owner_q <= OWN_NONE;
      we_q         <= 1'b0;
    end else begin
      resp_owner_q <= resp_owner_d;
      we_q         <= we_d;
    end
  end

  always_comb begin
    resp_owner_d = OWN_NONE;
    we_d         = 1'b0;
    if (if_gnt) begin
      resp_owner_d = OWN_IF;
    end else if (dm_gnt) begin
      resp_owner_d = OWN_DM;
      we_d         = dm_we_i;
    end
  end

  always_comb begin
    if_rvalid_o = 1'b0;
    if_rdata_o  = '0;
    dm_rvalid_o = 1'b0;
    dm_rdata_o  = '0;
    if (!rst_i) begin
      case (resp_owner_q)
        OWN_IF: begin
          if_rvalid_o = !flush_i;
          if_rdata_o  = flush_i ? '0 : mem_rdata_i;
        end
        OWN_DM: begin
          dm_rvalid_o = 1'b1;
          dm_rdata_o  = we_q ? '0 : mem_rdata_i;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned BW   = DW / 8;
  localparam int unsigned SMAX = 4;
  localparam int unsigned MW   = 256;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          if_req_i, flush_i, dm_req_i, dm_we_i;
  logic [AW-1:0] if_addr_i, dm_addr_i;
  logic [BW-1:0] dm_be_i;
  logic [DW-1:0] dm_wdata_i;
  logic          if_gnt_o, if_rvalid_o, dm_gnt_o, dm_rvalid_o;
  logic [DW-1:0] if_rdata_o, dm_rdata_o;
  logic          mem_en_o, mem_we_o;
  logic [BW-1:0] mem_be_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o, mem_rdata_i;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .STARVE_MAX(SMAX)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_gnt_o   (if_gnt_o),
    .if_rvalid_o(if_rvalid_o),
    .if_rdata_o (if_rdata_o),
    .flush_i    (flush_i),
    .dm_req_i   (dm_req_i),
    .dm_we_i    (dm_we_i),
    .dm_be_i    (dm_be_i),
    .dm_addr_i  (dm_addr_i),
    .dm_wdata_i (dm_wdata_i),
    .dm_gnt_o   (dm_gnt_o),
    .dm_rvalid_o(dm_rvalid_o),
    .dm_rdata_o (dm_rdata_o),
    .mem_en_o   (mem_en_o),
    .mem_we_o   (mem_we_o),
    .mem_be_o   (mem_be_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i)
  );

  function automatic logic [31:0] seed_word(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'hA5C3_0F1E;
  endfunction

  // Unified memory driven only by the DUT's mem_* outputs; junk when not reading.
  logic          init_mem = 1'b1;
  logic [31:0]   env_mem [MW];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < MW; i++) env_mem[i] <= seed_word(i);
    end else if (mem_en_o && mem_we_o) begin
      for (int b = 0; b < BW; b++)
        if (mem_be_o[b]) env_mem[mem_addr_o[9:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
    end
    mem_rdata_i <= (mem_en_o && !mem_we_o) ? env_mem[mem_addr_o[9:2]] : $urandom;
  end

  // Reference model state.
  logic [31:0] ref_mem [MW];
  int          prev_owner = 0;  // 0 none, 1 fetch, 2 data
  logic        prev_we    = 1'b0;
  logic [31:0] prev_data  = '0;
  int          losses     = 0;  // consecutive data wins over a waiting fetch
  logic        m_if_gnt, m_dm_gnt;
  logic        last_if_gnt, last_dm_gnt, last_if_rvalid, last_dm_rvalid;
  logic [31:0] last_dm_rdata;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic ifr, input logic [31:0] ifa, input logic dmr,
                      input logic dwe, input logic [3:0] dbe, input logic [31:0] dad,
                      input logic [31:0] dwd, input logic fl, input logic rs);
    logic eig, edg, eiv, edv;
    rst_i = rs; flush_i = fl;
    if_req_i = ifr; if_addr_i = ifa;
    dm_req_i = dmr; dm_we_i = dwe; dm_be_i = dbe; dm_addr_i = dad; dm_wdata_i = dwd;
    @(negedge clk);
    eig = !rs && ifr && !fl && (!dmr || losses == SMAX);
    edg = !rs && dmr && !eig;
    eiv = !rs && prev_owner == 1 && !fl;
    edv = !rs && prev_owner == 2;
    check("if_gnt", if_gnt_o, eig);
    check("dm_gnt", dm_gnt_o, edg);
    check("mem_en", mem_en_o, eig | edg);
    check("mem_we", mem_we_o, edg & dwe);
    check("mem_be", mem_be_o, eig ? 4'hF : (edg ? dbe : 4'h0));
    check("mem_addr", mem_addr_o, eig ? ifa : (edg ? dad : 32'h0));
    check("mem_wdata", mem_wdata_o, edg ? dwd : 32'h0);
    check("if_rvalid", if_rvalid_o, eiv);
    check("if_rdata", if_rdata_o, eiv ? prev_data : 32'h0);
    check("dm_rvalid", dm_rvalid_o, edv);
    check("dm_rdata", dm_rdata_o, (edv && !prev_we) ? prev_data : 32'h0);
    last_if_gnt = if_gnt_o; last_dm_gnt = dm_gnt_o;
    last_if_rvalid = if_rvalid_o; last_dm_rvalid = dm_rvalid_o; last_dm_rdata = dm_rdata_o;
    m_if_gnt = eig; m_dm_gnt = edg;
    if (rs) begin
      prev_owner = 0; prev_we = 1'b0; losses = 0;
    end else begin
      prev_owner = eig ? 1 : (edg ? 2 : 0);
      prev_we    = edg && dwe;
      if (eig) prev_data = ref_mem[ifa[9:2]];
      else if (edg && !dwe) prev_data = ref_mem[dad[9:2]];
      if (edg && dwe)
        for (int b = 0; b < 4; b++) if (dbe[b]) ref_mem[dad[9:2]][8*b +: 8] = dwd[8*b +: 8];
      if (!ifr || eig) losses = 0;
      else if (edg && losses < SMAX) losses++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    logic        ip, dp, dwe, fl, rs;
    logic [31:0] ia, da, wd, old;
    logic [3:0]  be;
    for (int i = 0; i < MW; i++) ref_mem[i] = seed_word(i);

    // Reset: every output must be zero.
    step(1'b1, 32'h4, 1'b1, 1'b1, 4'hF, 32'h8, 32'h1234, 1'b0, 1'b1);
    init_mem = 1'b0;
    step(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Fetch only, consecutive words.
    step(1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h4, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h8, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    idle();

    // Conflict: data wins, fetch granted in the response cycle.
    step(1'b1, 32'h10, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0, 1'b0, 1'b0);
    check("conflict_dm_first", last_dm_gnt, 1'b1);
    step(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("conflict_if_next", last_if_gnt, 1'b1);
    check("conflict_dm_rdata", last_dm_rdata, seed_word(32'h100 >> 2));
    idle();

    // Starvation: fetch gets every fifth slot.
    for (int c = 0; c < 10; c++) begin
      step(1'b1, 32'h20 + 32'(4 * c), 1'b1, 1'b0, 4'hF, 32'h80, 32'h0, 1'b0, 1'b0);
      check("starve_if", last_if_gnt, (c == 4 || c == 9));
      check("starve_dm", last_dm_gnt, !(c == 4 || c == 9));
    end
    idle();

    // Partial store then reload.
    old = ref_mem[32'h200 >> 2];
    step(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h200, 32'hDEAD_BEEF, 1'b0, 1'b0);
    idle();
    step(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h200, 32'h0, 1'b0, 1'b0);
    idle();
    check("store_merge", last_dm_rdata, {old[31:16], 16'hBEEF});

    // Flush in the fetch response cycle.
    step(1'b1, 32'h40, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h44, 1'b1, 1'b0, 4'hF, 32'h30, 32'h0, 1'b1, 1'b0);
    check("flush_if_rvalid", last_if_rvalid, 1'b0);
    check("flush_if_gnt", last_if_gnt, 1'b0);
    check("flush_dm_gnt", last_dm_gnt, 1'b1);
    idle();

    // Reset right after a load grant.
    step(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h50, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h60, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    check("rst_dm_rvalid", last_dm_rvalid, 1'b0);
    step(1'b1, 32'h60, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("rst_first_fetch", last_if_gnt, 1'b1);
    idle();

    // Random traffic with held requests.
    ip = 1'b0; dp = 1'b0; ia = '0; da = '0; wd = '0; be = '0; dwe = 1'b0;
    for (int n = 0; n < 800; n++) begin
      if (!ip && ($urandom % 3 != 0)) begin
        ip = 1'b1; ia = $urandom & 32'hFFFF_FFFC;
      end
      if (!dp && ($urandom % 2 != 0)) begin
        dp = 1'b1; da = $urandom & 32'hFFFF_FFFC; wd = $urandom;
        be = 4'($urandom); dwe = 1'($urandom);
      end
      fl = ($urandom % 8 == 0);
      rs = ($urandom % 40 == 0);
      step(ip, ia, dp, dwe, be, da, wd, fl, rs);
      if (m_if_gnt) ip = 1'b0;
      if (m_dm_gnt) dp = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
